// File: rtl/rf_tf_pkg.sv
// Shared definitions for the 8<->512 byte packer/unpacker pair:
// word layout, metadata field positions, control encodings and limits.
package rf_tf_pkg;

   // Word and metadata geometry
   localparam int DATA_W     = 512;
   localparam int WORD_W     = 520;
   localparam int META_W     = 112;
   localparam int WORD_BYTES = DATA_W / 8;
   localparam int IDX_W      = 6;

   // Metadata field positions
   localparam int LEN_MSB = 106;
   localparam int LEN_LSB = 96;
   localparam int ERR_BIT = 107;

   // Largest length the metadata field can report
   localparam int MAX_LEN = 2047;

   // Control byte [519:518] position-in-packet encoding
   typedef enum logic [1:0] {
      CTL_MID    = 2'b00,
      CTL_HEAD   = 2'b01,
      CTL_TAIL   = 2'b10,
      CTL_SINGLE = 2'b11
   } ctl_e;

   // Receive packer states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } rx_state_e;

   // Control byte: position code above the (valid bytes - 1) count
   function automatic logic [7:0] ctl_byte(input ctl_e pos, input logic [IDX_W-1:0] last_idx);
      return {pos, last_idx};
   endfunction

endpackage

// File: rtl/rf_byte_lane_pack.sv
// 64-byte shift-in register. Byte index k lands MSB-first at
// [(63-k)*8 +: 8]; word_nxt shows the register with the incoming byte
// already merged so a completing beat can be emitted the same cycle.
module rf_byte_lane_pack
   import rf_tf_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr,
   input  logic [IDX_W-1:0]  idx,
   input  logic [7:0]        din,
   output logic [DATA_W-1:0] word,
   output logic [DATA_W-1:0] word_nxt
);

   logic [DATA_W-1:0] lanes;

   // Merge the incoming byte into its lane; (63 - idx) equals ~idx for 6 bits
   always_comb begin
      word_nxt = lanes;
      if (wr) begin
         word_nxt[{~idx, 3'b000} +: 8] = din;
      end
   end

   // Hold the partial word; clearing after an emit keeps unfilled bytes zero
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         lanes <= '0;
      end else begin
         lanes <= word_nxt;
      end
   end

   assign word = lanes;

endmodule

// File: rtl/rf_8to512.sv
// Receive-side byte packer: 8-bit AXI-Stream in, 520-bit words
// (512 data + control byte) and one 112-bit metadata word per packet out.
module rf_8to512
   import rf_tf_pkg::*;
#(
   parameter int ALF_HOLD = 1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        m_axis_rx_tdata,
   input  logic              m_axis_rx_tvalid,
   input  logic              m_axis_rx_tlast,
   input  logic              m_axis_rx_tuser,
   output logic              m_axis_rx_tready,
   output logic [WORD_W-1:0] RF_8to512_out,
   output logic              RF_8to512_out_wr,
   output logic [META_W-1:0] RF_8to512_out_valid,
   output logic              RF_8to512_out_valid_wr,
   input  logic              RF_8to512_in_alf,
   output logic [15:0]       pktbyte_in_cnt,
   output logic [7:0]        pkt_in_cnt,
   output logic [7:0]        err_cnt
);

   // Internal byte count runs one past MAX_LEN so the 2048th byte
   // (index 2047) can still be stored; it then saturates there.
   localparam logic [11:0] LEN_CAP  = 12'(MAX_LEN + 1);
   localparam logic [11:0] LEN_LAST = 12'(MAX_LEN);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);

   function automatic logic [11:0] inc_sat(input logic [11:0] c);
      if (c >= LEN_CAP) begin
         return LEN_CAP;
      end
      return c + 12'd1;
   endfunction

   function automatic logic [10:0] sat_len(input logic [11:0] c);
      if (c > LEN_LAST) begin
         return 11'(MAX_LEN);
      end
      return c[10:0];
   endfunction

   rx_state_e state, state_nxt;

   logic              tready;
   logic              acc;
   logic              in_idle;
   logic [IDX_W-1:0]  byte_cnt;
   logic [IDX_W-1:0]  idx;
   logic [11:0]       len_cnt;
   logic [11:0]       cnt_cur;
   logic [11:0]       cnt_new;
   logic              first_word;
   logic              writable;
   logic              lane_wr;
   logic              word_full;
   logic              pkt_end;
   logic              emit;
   logic              lead;
   ctl_e              ctl;
   logic [IDX_W-1:0]  last_idx;
   logic [DATA_W-1:0] emit_data;
   logic [DATA_W-1:0] lane_word;
   logic [DATA_W-1:0] lane_word_nxt;
   logic [META_W-1:0] meta_nxt;
   logic              meta_err;

   logic [WORD_W-1:0] word_q;
   logic              word_wr_q;
   logic [META_W-1:0] meta_q;
   logic              meta_wr_q;
   logic [15:0]       byte_ctr;
   logic [7:0]        pkt_ctr;
   logic [7:0]        err_ctr;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: a lone tlast beat in IDLE is a whole packet, so stay
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (acc && !m_axis_rx_tlast) state_nxt = ST_RECV;
         ST_RECV: if (acc && m_axis_rx_tlast)  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: almost-full only gates the packet start when ALF_HOLD is set
   always_comb begin
      tready = 1'b0;
      if (!rst) begin
         case (state)
            ST_IDLE: tready = !RF_8to512_in_alf;
            ST_RECV: tready = (ALF_HOLD != 0) ? 1'b1 : !RF_8to512_in_alf;
            default: tready = 1'b0;
         endcase
      end
   end

   assign m_axis_rx_tready = tready;
   assign acc       = m_axis_rx_tvalid && tready;
   assign in_idle   = (state == ST_IDLE);
   assign idx       = in_idle ? '0 : byte_cnt;
   assign cnt_cur   = in_idle ? '0 : len_cnt;
   assign writable  = (cnt_cur < LEN_CAP);
   assign cnt_new   = inc_sat(cnt_cur);
   assign lane_wr   = acc && writable;
   assign pkt_end   = acc && m_axis_rx_tlast;
   // The word holding byte 2047 is not emitted early; oversize packets flush it at tlast
   assign word_full = lane_wr && !m_axis_rx_tlast && (idx == IDX_LAST) && (cnt_cur != LEN_LAST);
   assign emit      = word_full || pkt_end;

   rf_byte_lane_pack u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (emit),
      .wr       (lane_wr),
      .idx      (idx),
      .din      (m_axis_rx_tdata),
      .word     (lane_word),
      .word_nxt (lane_word_nxt)
   );

   // Build the outgoing word: position code plus last valid byte index
   always_comb begin
      lead = in_idle || first_word;
      if (pkt_end) begin
         ctl = lead ? CTL_SINGLE : CTL_TAIL;
      end else begin
         ctl = lead ? CTL_HEAD : CTL_MID;
      end
      if (pkt_end && !writable) begin
         // tlast byte was discarded: flush what is stored, ending at byte_cnt-1
         emit_data = lane_word;
         last_idx  = byte_cnt - IDX_W'(1);
      end else begin
         emit_data = lane_word_nxt;
         last_idx  = idx;
      end
   end

   // Metadata: saturated length and error (tuser or oversize)
   always_comb begin
      meta_err = m_axis_rx_tuser || (cnt_new > LEN_LAST);
      meta_nxt = '0;
      meta_nxt[LEN_MSB:LEN_LSB] = sat_len(cnt_new);
      meta_nxt[ERR_BIT] = meta_err;
   end

   // Per-packet tracking: byte index in word, running length, head flag
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt   <= '0;
         len_cnt    <= '0;
         first_word <= 1'b0;
      end else if (acc) begin
         len_cnt <= cnt_new;
         if (lane_wr) begin
            byte_cnt <= idx + IDX_W'(1);
         end
         if (in_idle) begin
            first_word <= 1'b1;
         end else if (word_full) begin
            first_word <= 1'b0;
         end
      end
   end

   // Registered word/metadata outputs with single-cycle strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q    <= '0;
         word_wr_q <= 1'b0;
         meta_q    <= '0;
         meta_wr_q <= 1'b0;
      end else begin
         word_wr_q <= emit;
         meta_wr_q <= pkt_end;
         if (emit) begin
            word_q <= {ctl_byte(ctl, last_idx), emit_data};
         end
         if (pkt_end) begin
            meta_q <= meta_nxt;
         end
      end
   end

   // Wrapping statistics counters
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_ctr <= '0;
         pkt_ctr  <= '0;
         err_ctr  <= '0;
      end else begin
         if (acc) begin
            byte_ctr <= byte_ctr + 16'd1;
         end
         if (pkt_end) begin
            pkt_ctr <= pkt_ctr + 8'd1;
            if (meta_err) begin
               err_ctr <= err_ctr + 8'd1;
            end
         end
      end
   end

   assign RF_8to512_out          = word_q;
   assign RF_8to512_out_wr       = word_wr_q;
   assign RF_8to512_out_valid    = meta_q;
   assign RF_8to512_out_valid_wr = meta_wr_q;
   assign pktbyte_in_cnt         = byte_ctr;
   assign pkt_in_cnt             = pkt_ctr;
   assign err_cnt                = err_ctr;

endmodule

// File: tb/tb_rf_8to512.sv
// Self-checking bench for rf_8to512: spec-derived vector table, hand
// sequences for flow control and reset, and random packets checked
// against a packet-level reference model.
module tb_rf_8to512;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   tdata;
   logic         tvalid, tlast, tuser, tready;
   logic [519:0] out_word;
   logic         out_wr;
   logic [111:0] meta;
   logic         meta_wr;
   logic         alf;
   logic [15:0]  byte_cnt;
   logic [7:0]   pkt_cnt, errs;

   always #5 clk = ~clk;

   rf_8to512 #(.ALF_HOLD(1)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .m_axis_rx_tdata        (tdata),
      .m_axis_rx_tvalid       (tvalid),
      .m_axis_rx_tlast        (tlast),
      .m_axis_rx_tuser        (tuser),
      .m_axis_rx_tready       (tready),
      .RF_8to512_out          (out_word),
      .RF_8to512_out_wr       (out_wr),
      .RF_8to512_out_valid    (meta),
      .RF_8to512_out_valid_wr (meta_wr),
      .RF_8to512_in_alf       (alf),
      .pktbyte_in_cnt         (byte_cnt),
      .pkt_in_cnt             (pkt_cnt),
      .err_cnt                (errs)
   );

   int compared   = 0;
   int mismatched = 0;
   int orphan_meta = 0;
   int cyc = 0;
   int acc_cyc = 0;

   logic [519:0] got_w[$], exp_w[$];
   logic [111:0] got_m[$], exp_m[$];
   logic [7:0]   pkt_data [0:2199];
   logic [15:0]  m_bytes;
   logic [7:0]   m_pkts, m_errs;
   logic [519:0] lastw;
   logic         stuck;
   int           t0;

   typedef struct {
      int         len;
      bit         user;
      bit         gaps;
      int         nwords;
      logic [1:0] last_ctl;
      logic [5:0] last_cnt;
      int         mlen;
      bit         merr;
   } vec_t;
   vec_t tv[7];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_wr)  got_w.push_back(out_word);
      if (meta_wr) got_m.push_back(meta);
      if (meta_wr && !out_wr) orphan_meta++;
   end

   task automatic check(input string name, input logic [519:0] act, input logic [519:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Reference: split the first min(n,2048) bytes into 64-byte words
   task automatic model_pkt(input int n, input bit user);
      int w, nw, nb;
      logic [519:0] wd;
      logic [111:0] m;
      logic [1:0]   c;
      w  = (n > 2048) ? 2048 : n;
      nw = (w + 63) / 64;
      for (int i = 0; i < nw; i++) begin
         wd = '0;
         nb = (w - i*64 > 64) ? 64 : w - i*64;
         for (int b = 0; b < nb; b++) wd[(63-b)*8 +: 8] = pkt_data[i*64 + b];
         if (nw == 1)           c = 2'b11;
         else if (i == 0)       c = 2'b01;
         else if (i == nw - 1)  c = 2'b10;
         else                   c = 2'b00;
         wd[519:518] = c;
         wd[517:512] = 6'(nb - 1);
         exp_w.push_back(wd);
      end
      m = '0;
      m[106:96] = 11'((n > 2047) ? 2047 : n);
      m[107] = user || (n > 2047);
      exp_m.push_back(m);
      m_bytes = m_bytes + 16'(n);
      m_pkts  = m_pkts + 8'd1;
      if (m[107]) m_errs = m_errs + 8'd1;
   endtask

   task automatic beat(input logic [7:0] d, input logic last, input logic user);
      int guard = 0;
      @(negedge clk);
      tvalid = 1'b1; tdata = d; tlast = last; tuser = user;
      #1;
      while (!tready && guard < 500) begin
         @(negedge clk); #1; guard++;
      end
      if (!tready) begin
         compared++; mismatched++;
         $display("FAIL tready_timeout: tready=0 after %0d cycles, required 1", guard);
      end
      @(posedge clk);
      acc_cyc = cyc;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
   endtask

   task automatic send_pkt(input int n, input bit user, input bit gaps);
      for (int k = 0; k < n; k++) begin
         if (gaps && $urandom_range(0, 2) == 0) idle_cycle();
         beat(pkt_data[k], k == n - 1, user && (k == n - 1));
      end
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   task automatic compare_all(input string name);
      int nw, nm;
      check($sformatf("%s_nwords", name), 520'(got_w.size()), 520'(exp_w.size()));
      check($sformatf("%s_nmeta", name), 520'(got_m.size()), 520'(exp_m.size()));
      nw = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
      nm = (got_m.size() < exp_m.size()) ? got_m.size() : exp_m.size();
      for (int i = 0; i < nw; i++) check($sformatf("%s_word%0d", name, i), got_w[i], exp_w[i]);
      for (int i = 0; i < nm; i++) check($sformatf("%s_meta%0d", name, i), 520'(got_m[i]), 520'(exp_m[i]));
      check($sformatf("%s_pktbyte_in_cnt", name), 520'(byte_cnt), 520'(m_bytes));
      check($sformatf("%s_pkt_in_cnt", name), 520'(pkt_cnt), 520'(m_pkts));
      check($sformatf("%s_err_cnt", name), 520'(errs), 520'(m_errs));
      got_w.delete(); exp_w.delete(); got_m.delete(); exp_m.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_bytes = '0; m_pkts = '0; m_errs = '0;
      got_w.delete(); exp_w.delete(); got_m.delete(); exp_m.delete();
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = '0; alf = 1'b0;
      m_bytes = '0; m_pkts = '0; m_errs = '0;

      tv[0] = '{60,   1'b0, 1'b0, 1,  2'b11, 6'd59, 60,   1'b0};
      tv[1] = '{64,   1'b0, 1'b0, 1,  2'b11, 6'd63, 64,   1'b0};
      tv[2] = '{130,  1'b0, 1'b1, 3,  2'b10, 6'd1,  130,  1'b0};
      tv[3] = '{1,    1'b0, 1'b0, 1,  2'b11, 6'd0,  1,    1'b0};
      tv[4] = '{65,   1'b1, 1'b0, 2,  2'b10, 6'd0,  65,   1'b1};
      tv[5] = '{128,  1'b0, 1'b1, 2,  2'b10, 6'd63, 128,  1'b0};
      tv[6] = '{2100, 1'b0, 1'b0, 32, 2'b10, 6'd63, 2047, 1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tready", 520'(tready), 520'(0));
      check("rst_out_wr", 520'(out_wr), 520'(0));
      check("rst_valid_wr", 520'(meta_wr), 520'(0));
      check("rst_out", out_word, 520'(0));
      check("rst_meta", 520'(meta), 520'(0));
      check("rst_counters", 520'({byte_cnt, pkt_cnt, errs}), 520'(0));
      rst = 1'b0;

      // Vector table with incrementing byte pattern
      for (int i = 0; i < 7; i++) begin
         for (int k = 0; k < tv[i].len; k++) pkt_data[k] = 8'(k);
         model_pkt(tv[i].len, tv[i].user);
         send_pkt(tv[i].len, tv[i].user, tv[i].gaps);
         idle_cycle();
         settle();
         check($sformatf("row%0d_words", i), 520'(got_w.size()), 520'(tv[i].nwords));
         if (got_w.size() > 0) begin
            lastw = got_w[got_w.size() - 1];
            check($sformatf("row%0d_last_ctl", i), 520'(lastw[519:518]), 520'(tv[i].last_ctl));
            check($sformatf("row%0d_last_cnt", i), 520'(lastw[517:512]), 520'(tv[i].last_cnt));
            if (tv[i].len == 60) begin
               check("p60_byte0", 520'(lastw[511:504]), 520'(8'h00));
               check("p60_byte59", 520'(lastw[39:32]), 520'(8'h3B));
               check("p60_tail_zero", 520'(lastw[31:0]), 520'(0));
            end
         end
         if (got_m.size() > 0) begin
            check($sformatf("row%0d_len", i), 520'(got_m[0][106:96]), 520'(tv[i].mlen));
            check($sformatf("row%0d_err", i), 520'(got_m[0][107]), 520'(tv[i].merr));
         end
         compare_all($sformatf("row%0d", i));
      end

      // Back-to-back single-byte packets, error on the second
      do_reset();
      pkt_data[0] = 8'hA5;
      model_pkt(1, 1'b0);
      send_pkt(1, 1'b0, 1'b0);
      t0 = acc_cyc;
      pkt_data[0] = 8'h5A;
      model_pkt(1, 1'b1);
      send_pkt(1, 1'b1, 1'b0);
      check("b2b_gap", 520'(acc_cyc - t0), 520'(1));
      idle_cycle();
      settle();
      if (got_m.size() == 2) begin
         check("b2b_err0", 520'(got_m[0][107]), 520'(0));
         check("b2b_err1", 520'(got_m[1][107]), 520'(1));
      end
      check("b2b_pkt_in_cnt", 520'(pkt_cnt), 520'(2));
      check("b2b_err_cnt", 520'(errs), 520'(1));
      compare_all("b2b");

      // Almost-full: holds tready low in IDLE, ignored mid-packet
      for (int k = 0; k < 10; k++) pkt_data[k] = 8'($urandom);
      model_pkt(10, 1'b0);
      @(negedge clk);
      alf = 1'b1; tvalid = 1'b1; tdata = pkt_data[0]; tlast = 1'b0; tuser = 1'b0;
      stuck = 1'b0;
      repeat (6) begin
         #1; if (tready) stuck = 1'b1;
         @(negedge clk);
      end
      check("alf_idle_hold", 520'(stuck), 520'(0));
      alf = 1'b0;
      #1;
      check("alf_drop_tready", 520'(tready), 520'(1));
      @(posedge clk);
      @(negedge clk);
      tvalid = 1'b0; alf = 1'b1;
      #1;
      check("alf_mid_pkt_tready", 520'(tready), 520'(1));
      for (int k = 1; k < 10; k++) beat(pkt_data[k], k == 9, 1'b0);
      idle_cycle();
      #1;
      check("alf_idle_again", 520'(tready), 520'(0));
      alf = 1'b0;
      settle();
      compare_all("alf");

      // Random packets against the reference model
      for (int p = 0; p < 25; p++) begin
         int n;
         bit u, g;
         n = $urandom_range(1, 200);
         u = ($urandom_range(0, 3) == 0);
         g = $urandom_range(0, 1);
         for (int k = 0; k < n; k++) pkt_data[k] = 8'($urandom);
         model_pkt(n, u);
         send_pkt(n, u, g);
         idle_cycle();
         settle();
         compare_all($sformatf("rnd%0d", p));
      end

      // Reset mid-packet discards the partial word and length
      for (int k = 0; k < 10; k++) beat(8'($urandom), 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_tready", 520'(tready), 520'(0));
      repeat (2) @(negedge clk);
      check("midrst_counters", 520'({byte_cnt, pkt_cnt, errs}), 520'(0));
      rst = 1'b0; tvalid = 1'b0;
      settle();
      check("midrst_no_words", 520'(got_w.size()), 520'(0));
      check("midrst_no_meta", 520'(got_m.size()), 520'(0));
      got_w.delete(); got_m.delete();
      m_bytes = '0; m_pkts = '0; m_errs = '0;
      for (int k = 0; k < 5; k++) pkt_data[k] = 8'($urandom);
      model_pkt(5, 1'b0);
      send_pkt(5, 1'b0, 1'b0);
      idle_cycle();
      settle();
      compare_all("post_rst");

      check("meta_without_word", 520'(orphan_meta), 520'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
